// File: rtl/toast_fetch_if.sv
// rtl/toast_fetch_if.sv - fetch-side bundle: imem req/gnt/rvalid bus and ID delivery/redirect signals
interface toast_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        id_branch_taken;
    logic [31:0] id_pc_dest;
    logic        id_stall;

    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  id_branch_taken, id_pc_dest, id_stall,
        output if_valid, if_pc, if_instr
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output id_branch_taken, id_pc_dest, id_stall,
        input  if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/toast_fetch.sv
// rtl/toast_fetch.sv - Toast RV32I fetch front end: credit-limited imem requests, in-flight PC queue, instruction buffer
module toast_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 3
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    toast_fetch_if.master bus
);
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [CW:0]   CREDITS  = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] out_cnt_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [PW-1:0] pq_wr;
    logic [PW-1:0] pq_rd;
    logic [PW-1:0] fb_wr;
    logic [PW-1:0] fb_rd;
    logic [31:0]   pq_pc    [DEPTH];
    logic [31:0]   fb_pc    [DEPTH];
    logic [31:0]   fb_instr [DEPTH];

    logic valid;
    logic redirect;
    logic gnt_fire;
    logic rsp_fire;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Credits cover both in-flight requests and buffered words, so a returning
    // response always finds a free buffer slot.
    assign bus.imem_req  = resetn_i && (({1'b0, out_cnt} + {1'b0, count}) < CREDITS);
    assign bus.imem_addr = {fetch_pc[31:2], 2'b00};

    assign redirect = bus.id_branch_taken;
    assign gnt_fire = bus.imem_req && bus.imem_gnt;
    assign rsp_fire = bus.imem_rvalid && (out_cnt != '0);
    assign push     = rsp_fire && !redirect && (drop_cnt == '0);
    assign valid    = (count != '0);
    assign pop      = valid && !bus.id_stall && !redirect;

    assign bus.if_valid = valid;
    assign bus.if_pc    = valid ? fb_pc[fb_rd]    : '0;
    assign bus.if_instr = valid ? fb_instr[fb_rd] : '0;

    always_comb begin
        out_cnt_nxt = out_cnt;
        if (gnt_fire && !rsp_fire) begin
            out_cnt_nxt = out_cnt + 1'b1;
        end else if (rsp_fire && !gnt_fire) begin
            out_cnt_nxt = out_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            fetch_pc <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
            count    <= '0;
            pq_wr    <= '0;
            pq_rd    <= '0;
            fb_wr    <= '0;
            fb_rd    <= '0;
        end else begin
            out_cnt <= out_cnt_nxt;
            if (gnt_fire) pq_wr <= ptr_inc(pq_wr);
            if (rsp_fire) pq_rd <= ptr_inc(pq_rd);
            if (redirect) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= {bus.id_pc_dest[31:2], 2'b00};
                drop_cnt <= out_cnt_nxt;
                count    <= '0;
                fb_wr    <= '0;
                fb_rd    <= '0;
            end else begin
                if (gnt_fire) fetch_pc <= fetch_pc + 32'd4;
                if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
                if (push) fb_wr <= ptr_inc(fb_wr);
                if (pop)  fb_rd <= ptr_inc(fb_rd);
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt_fire) pq_pc[pq_wr] <= bus.imem_addr;
        if (push) begin
            fb_pc[fb_wr]    <= pq_pc[pq_rd];
            fb_instr[fb_wr] <= bus.imem_rdata;
        end
    end
endmodule
